// File: rtl/ether_pkg.sv
// Shared types and defaults for the Ethernet transmit path.
package ether_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // 96 bit times at 2 bits per RMII clock
  localparam int IFG_CYCLES_DEF = 48;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

endpackage

// File: rtl/ifg_timer.sv
// Inter-frame gap down-counter: load on end of frame, count while in gap, done at zero.
module ifg_timer #(
  parameter int CYCLES = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = (CYCLES > 0) ? W'(CYCLES - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ether_tx_arbiter.sv
// Two-requester round-robin frame arbiter feeding an RMII transmitter; zero-latency byte mux, grant held per frame.
// ETHER_TX_ARB_STATS_EN adds per-requester completed-frame counters a_frames/b_frames.
module ether_tx_arbiter
  import ether_pkg::*;
#(
  parameter int IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic [1:0]       grant,
  output logic             busy
`ifdef ETHER_TX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] a_frames,
  output logic [CNT_W-1:0] b_frames
`endif
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic [1:0] r_grant;
  logic       r_ptr_b;
  logic       w_req;
  logic       w_pick_b;
  logic       w_eof;
  logic       w_gap_cnt_en;
  logic       w_gap_done;

  assign w_req        = a_valid | b_valid;
  assign w_pick_b     = b_valid & (~a_valid | r_ptr_b);
  assign w_eof        = tx_valid & tx_ready & tx_last;
  assign w_gap_cnt_en = (r_state == ST_GAP);

  ifg_timer #(
    .CYCLES (IFG_CYCLES)
  ) u_ifg_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_eof),
    .i_count (w_gap_cnt_en),
    .o_done  (w_gap_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = ST_SEND;
      ST_SEND: if (w_eof) w_next = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (w_gap_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    if (r_state == ST_SEND) begin
      case (r_grant)
        GNT_A: begin
          tx_valid = a_valid;
          tx_data  = a_data;
          tx_last  = a_last;
          a_ready  = tx_ready;
        end
        GNT_B: begin
          tx_valid = b_valid;
          tx_data  = b_data;
          tx_last  = b_last;
          b_ready  = tx_ready;
        end
        default: ;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

  // Pointer flips to the requester not just served once its frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= GNT_NONE;
      r_ptr_b <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) r_grant <= w_pick_b ? GNT_B : GNT_A;
        ST_SEND: if (w_eof) begin
          r_grant <= GNT_NONE;
          r_ptr_b <= r_grant[0];
        end
        default: ;
      endcase
    end
  end

`ifdef ETHER_TX_ARB_STATS_EN
  logic [CNT_W-1:0] r_a_frames;
  logic [CNT_W-1:0] r_b_frames;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_frames <= '0;
      r_b_frames <= '0;
    end else if (w_eof) begin
      if (r_grant[0]) r_a_frames <= r_a_frames + 1'b1;
      else            r_b_frames <= r_b_frames + 1'b1;
    end
  end

  assign a_frames = r_a_frames;
  assign b_frames = r_b_frames;
`endif

endmodule
